// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared states, gate patterns and defaults for the H-bridge driver
package hbridge_pkg;
  typedef enum logic [2:0] {OFF, FREE, DT_ON, DRIVE, DT_OFF} state_t;
  localparam logic [3:0] GATES_OFF    = 4'b0000;
  localparam logic [3:0] GATES_FREE   = 4'b0101;
  localparam logic [3:0] GATES_POS    = 4'b1001;
  localparam logic [3:0] GATES_NEG    = 4'b0110;
  localparam logic [3:0] GATES_DT_POS = 4'b0001;
  localparam logic [3:0] GATES_DT_NEG = 4'b0100;
  localparam int DEAD_CYCLES_DEFAULT = 8;
endpackage

// File: rtl/hbridge_driver_dead_timer.sv
// dead_timer: down-counter loaded on dead-time entry; done while it reads zero
module dead_timer #(
  parameter int DEAD_CYCLES = 8,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? CNT_W'(DEAD_CYCLES - 1) : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/hbridge_driver.sv
// hbridge_driver: PWM carrier + sign to four dead-time-protected H-bridge gate drives
module hbridge_driver
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic wave_out,
  input  logic sign,
  input  logic fault_in,
  input  logic fault_clr,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic fault_latched,
  output logic pulse_drop
);
  state_t state_q, state_d;
  logic s_q, s_d;
  logic [3:0] gates_q, gates_d;
  logic fault_latched_q, fault_latched_d;
  logic pulse_drop_q, pulse_drop_d;
  logic load, done;
  dead_timer #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .done(done)
  );
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    load = 1'b0;
    pulse_drop_d = 1'b0;
    fault_latched_d = fault_in | (fault_latched_q & ~fault_clr);
    if (fault_in | ~en) state_d = OFF;
    else
      case (state_q)
        OFF:    if (!fault_latched_q) state_d = FREE;
        FREE:   if (wave_out) begin state_d = DT_ON; s_d = sign; load = 1'b1; end
        // a pulse that ends before the dead time expires never reaches the high side
        DT_ON:  if (!wave_out) begin state_d = FREE; pulse_drop_d = 1'b1; end
                else if (done) state_d = DRIVE;
        DRIVE:  if (!wave_out) begin state_d = DT_OFF; load = 1'b1; end
        DT_OFF: if (done) state_d = FREE;
        default: state_d = OFF;
      endcase
    gates_d = state_d == FREE ? GATES_FREE :
              state_d == DRIVE ? (s_d ? GATES_NEG : GATES_POS) :
              (state_d == DT_ON || state_d == DT_OFF) ? (s_d ? GATES_DT_NEG : GATES_DT_POS) :
              GATES_OFF;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= OFF;
      s_q <= 1'b0;
      gates_q <= GATES_OFF;
      fault_latched_q <= 1'b0;
      pulse_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      gates_q <= gates_d;
      fault_latched_q <= fault_latched_d;
      pulse_drop_q <= pulse_drop_d;
    end
  assign {A, B, C, D} = gates_q;
  assign fault_latched = fault_latched_q;
  assign pulse_drop = pulse_drop_q;
endmodule
